// File: rtl/usb_rx_pkt_ctrl_if.sv
// Signal bundle between the USB RX decode path, the packet controller and the packet FIFO.
// The controller uses the master modport; the decode/FIFO side uses slave.
interface usb_rx_pkt_ctrl_if #(
    parameter int OCC_W = 7,
    parameter int CNT_W = 7
);
    logic             d_edge;
    logic             eop;
    logic             byte_received;
    logic [7:0]       rcv_data;
    logic [OCC_W-1:0] buffer_occupancy;

    logic             rx_transfer_active;
    logic             rx_error;
    logic [3:0]       rx_packet;
    logic             rx_data_ready;
    logic [7:0]       rx_packet_data;
    logic             store_rx_packet_data;
    logic             flush;
    logic [15:0]      rx_token;
    logic [CNT_W-1:0] rx_byte_count;

    modport master (
        input  d_edge, eop, byte_received, rcv_data, buffer_occupancy,
        output rx_transfer_active, rx_error, rx_packet, rx_data_ready,
               rx_packet_data, store_rx_packet_data, flush, rx_token, rx_byte_count
    );

    modport slave (
        output d_edge, eop, byte_received, rcv_data, buffer_occupancy,
        input  rx_transfer_active, rx_error, rx_packet, rx_data_ready,
               rx_packet_data, store_rx_packet_data, flush, rx_token, rx_byte_count
    );
endinterface

// File: rtl/usb_rx_pkt_ctrl.sv
// Packet-level USB full-speed RX controller: SYNC/PID checking, token capture and
// streaming of DATA payload bytes into the packet FIFO, with oversize/full detection.
module usb_rx_pkt_ctrl #(
    parameter int BUF_DEPTH   = 64,
    parameter int MAX_PAYLOAD = 64,
    parameter int OCC_W       = $clog2(BUF_DEPTH) + 1,
    parameter int CNT_W       = $clog2(MAX_PAYLOAD + 3)
) (
    input  logic               clk,
    input  logic               n_rst,
    usb_rx_pkt_ctrl_if.master  bus
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SYNC     = 3'd1;
    localparam logic [2:0] PID      = 3'd2;
    localparam logic [2:0] TOKEN    = 3'd3;
    localparam logic [2:0] DATA     = 3'd4;
    localparam logic [2:0] WAIT_EOP = 3'd5;
    localparam logic [2:0] ERR      = 3'd6;
    localparam logic [2:0] DONE     = 3'd7;

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PAYLOAD + 2);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(BUF_DEPTH);

    logic [2:0]       state_q, state_d;
    logic             tok_idx_q, tok_idx_d;
    logic             active_q, active_d;
    logic             error_q, error_d;
    logic [3:0]       packet_q, packet_d;
    logic             ready_q, ready_d;
    logic [7:0]       data_q, data_d;
    logic             store_q, store_d;
    logic             flush_q, flush_d;
    logic [15:0]      token_q, token_d;
    logic [CNT_W-1:0] count_q, count_d;

    // byte_received is always examined before eop; eop is a held level, so it is
    // still visible in the cycle after a coincident byte.
    always_comb begin
        state_d   = state_q;
        tok_idx_d = tok_idx_q;
        error_d   = error_q;
        packet_d  = packet_q;
        ready_d   = 1'b0;
        data_d    = data_q;
        store_d   = 1'b0;
        flush_d   = 1'b0;
        token_d   = token_q;
        count_d   = count_q;

        case (state_q)
            IDLE: begin
                if (bus.d_edge) begin
                    state_d = SYNC;
                    error_d = 1'b0;
                    count_d = '0;
                end
            end
            SYNC: begin
                if (bus.byte_received) begin
                    state_d = (bus.rcv_data == 8'h80) ? PID : ERR;
                end else if (bus.eop) begin
                    state_d = ERR;
                end
            end
            PID: begin
                if (bus.byte_received) begin
                    if (bus.rcv_data[7:4] != ~bus.rcv_data[3:0]) begin
                        state_d = ERR;
                    end else begin
                        packet_d = bus.rcv_data[3:0];
                        case (bus.rcv_data[3:0])
                            4'b0001, 4'b1001, 4'b1101: begin
                                state_d   = TOKEN;
                                tok_idx_d = 1'b0;
                            end
                            4'b0011, 4'b1011: begin
                                state_d = DATA;
                                flush_d = 1'b1;
                            end
                            4'b0010, 4'b1010, 4'b1110: state_d = WAIT_EOP;
                            default:                   state_d = ERR;
                        endcase
                    end
                end else if (bus.eop) begin
                    state_d = ERR;
                end
            end
            TOKEN: begin
                if (bus.byte_received) begin
                    if (!tok_idx_q) begin
                        token_d[7:0] = bus.rcv_data;
                        tok_idx_d    = 1'b1;
                    end else begin
                        token_d[15:8] = bus.rcv_data;
                        state_d       = WAIT_EOP;
                    end
                end else if (bus.eop) begin
                    state_d = ERR;
                end
            end
            DATA: begin
                if (bus.byte_received) begin
                    if (count_q == MAX_CNT || bus.buffer_occupancy == FULL_OCC) begin
                        state_d = ERR;
                    end else begin
                        store_d = 1'b1;
                        data_d  = bus.rcv_data;
                        count_d = count_q + CNT_W'(1);
                    end
                end else if (bus.eop) begin
                    state_d = (count_q < CNT_W'(2)) ? ERR : DONE;
                end
            end
            WAIT_EOP: begin
                if (bus.byte_received) begin
                    state_d = ERR;
                end else if (bus.eop) begin
                    state_d = DONE;
                end
            end
            ERR: begin
                if (bus.eop) begin
                    state_d = IDLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Status outputs are decoded from the next state so they line up with it.
        if (state_d == ERR) begin
            error_d = 1'b1;
        end
        if (state_d == DONE) begin
            ready_d = 1'b1;
        end
        active_d = (state_d != IDLE) && (state_d != DONE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            tok_idx_q <= 1'b0;
            active_q  <= 1'b0;
            error_q   <= 1'b0;
            packet_q  <= 4'h0;
            ready_q   <= 1'b0;
            data_q    <= 8'h00;
            store_q   <= 1'b0;
            flush_q   <= 1'b0;
            token_q   <= 16'h0000;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            tok_idx_q <= tok_idx_d;
            active_q  <= active_d;
            error_q   <= error_d;
            packet_q  <= packet_d;
            ready_q   <= ready_d;
            data_q    <= data_d;
            store_q   <= store_d;
            flush_q   <= flush_d;
            token_q   <= token_d;
            count_q   <= count_d;
        end
    end

    assign bus.rx_transfer_active   = active_q;
    assign bus.rx_error             = error_q;
    assign bus.rx_packet            = packet_q;
    assign bus.rx_data_ready        = ready_q;
    assign bus.rx_packet_data       = data_q;
    assign bus.store_rx_packet_data = store_q;
    assign bus.flush                = flush_q;
    assign bus.rx_token             = token_q;
    assign bus.rx_byte_count        = count_q;

endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// Directed testbench for usb_rx_pkt_ctrl with a small FIFO/payload configuration.
// Inputs change 1ns after the falling edge; pulse outputs are logged on the falling edge.
module tb_usb_rx_pkt_ctrl;

    localparam int BUF_DEPTH   = 16;
    localparam int MAX_PAYLOAD = 8;
    localparam int OCC_W       = $clog2(BUF_DEPTH) + 1;
    localparam int CNT_W       = $clog2(MAX_PAYLOAD + 3);

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    usb_rx_pkt_ctrl_if #(.OCC_W(OCC_W), .CNT_W(CNT_W)) bus();

    usb_rx_pkt_ctrl #(
        .BUF_DEPTH(BUF_DEPTH), .MAX_PAYLOAD(MAX_PAYLOAD), .OCC_W(OCC_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int store_cnt = 0;
    int flush_cnt = 0;
    int ready_cnt = 0;
    int last_flush_cyc = -1;
    logic [7:0] store_log [0:255];
    int store_cyc [0:255];

    // Pulse log: every 1-cycle strobe is high across exactly one falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.store_rx_packet_data && store_cnt < 256) begin
            store_log[store_cnt] = bus.rx_packet_data;
            store_cyc[store_cnt] = cyc;
            store_cnt = store_cnt + 1;
        end
        if (bus.flush) begin
            flush_cnt = flush_cnt + 1;
            last_flush_cyc = cyc;
        end
        if (bus.rx_data_ready) begin
            ready_cnt = ready_cnt + 1;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic start_pkt();
        tick();
        bus.d_edge = 1'b1;
        tick();
        bus.d_edge = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        bus.byte_received = 1'b1;
        bus.rcv_data      = b;
        tick();
        bus.byte_received = 1'b0;
    endtask

    task automatic finish_eop();
        tick();
        bus.eop = 1'b1;
        tick(2);
        bus.eop = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        tick(2);
        checks++;
        if ({bus.rx_transfer_active, bus.rx_error, bus.rx_packet, bus.rx_data_ready,
             bus.rx_packet_data, bus.store_rx_packet_data, bus.flush, bus.rx_token,
             bus.rx_byte_count} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got nonzero output, token=%h packet=%h count=%0d",
                     bus.rx_token, bus.rx_packet, bus.rx_byte_count);
        end
        n_rst = 1'b1;
        tick(2);
        checks++;
        if (bus.rx_transfer_active !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle_active: got %b expected 0", bus.rx_transfer_active);
        end
    endtask

    task automatic test_out_token();
        int base_r;
        base_r = ready_cnt;
        start_pkt();
        checks++;
        if (bus.rx_transfer_active !== 1'b1) begin
            errors++;
            $display("[TB] FAIL out_active: got %b expected 1", bus.rx_transfer_active);
        end
        send_byte(8'h80);
        send_byte(8'hE1);
        send_byte(8'h34);
        send_byte(8'h12);
        tick();
        bus.eop = 1'b1;
        tick();
        checks++;
        if ({bus.rx_data_ready, bus.rx_transfer_active} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL out_ready_edge: got ready=%b active=%b expected ready=1 active=0",
                     bus.rx_data_ready, bus.rx_transfer_active);
        end
        tick();
        bus.eop = 1'b0;
        checks++;
        if (bus.rx_data_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL out_ready_width: got %b expected 0", bus.rx_data_ready);
        end
        tick();
        checks++;
        if (bus.rx_packet !== 4'h1) begin
            errors++;
            $display("[TB] FAIL out_pid: got %h expected 1", bus.rx_packet);
        end
        checks++;
        if (bus.rx_token !== 16'h1234) begin
            errors++;
            $display("[TB] FAIL out_token: got %h expected 1234", bus.rx_token);
        end
        checks++;
        if (bus.rx_error !== 1'b0 || ready_cnt - base_r !== 1) begin
            errors++;
            $display("[TB] FAIL out_status: got error=%b ready_pulses=%0d expected 0 and 1",
                     bus.rx_error, ready_cnt - base_r);
        end
    endtask

    task automatic test_data0();
        logic [7:0] exp_bytes [5] = '{8'h11, 8'h22, 8'h33, 8'hA5, 8'h5A};
        int base_s, base_f, base_r;
        base_s = store_cnt;
        base_f = flush_cnt;
        base_r = ready_cnt;
        start_pkt();
        send_byte(8'h80);
        send_byte(8'hC3);
        checks++;
        if (bus.flush !== 1'b1) begin
            errors++;
            $display("[TB] FAIL data0_flush_timing: got %b expected 1", bus.flush);
        end
        for (int i = 0; i < 5; i++) begin
            send_byte(exp_bytes[i]);
        end
        finish_eop();
        checks++;
        if (store_cnt - base_s !== 5) begin
            errors++;
            $display("[TB] FAIL data0_store_count: got %0d expected 5", store_cnt - base_s);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (store_log[base_s + i] !== exp_bytes[i]) begin
                errors++;
                $display("[TB] FAIL data0_byte%0d: got %h expected %h", i, store_log[base_s + i], exp_bytes[i]);
            end
        end
        checks++;
        if (flush_cnt - base_f !== 1 || store_cyc[base_s] <= last_flush_cyc) begin
            errors++;
            $display("[TB] FAIL data0_flush_order: got flushes=%0d flush_cyc=%0d first_store_cyc=%0d expected 1 flush before store",
                     flush_cnt - base_f, last_flush_cyc, store_cyc[base_s]);
        end
        checks++;
        if (bus.rx_byte_count !== CNT_W'(5)) begin
            errors++;
            $display("[TB] FAIL data0_byte_count: got %0d expected 5", bus.rx_byte_count);
        end
        checks++;
        if (ready_cnt - base_r !== 1 || bus.rx_packet !== 4'h3 || bus.rx_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL data0_status: got ready=%0d pid=%h error=%b expected 1 3 0",
                     ready_cnt - base_r, bus.rx_packet, bus.rx_error);
        end
    endtask

    task automatic test_bad_sync();
        int base_s, base_r;
        base_s = store_cnt;
        base_r = ready_cnt;
        start_pkt();
        send_byte(8'h81);
        checks++;
        if (bus.rx_error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL badsync_error: got %b expected 1", bus.rx_error);
        end
        finish_eop();
        checks++;
        if (bus.rx_error !== 1'b1 || bus.rx_transfer_active !== 1'b0) begin
            errors++;
            $display("[TB] FAIL badsync_hold: got error=%b active=%b expected 1 0",
                     bus.rx_error, bus.rx_transfer_active);
        end
        checks++;
        if (ready_cnt - base_r !== 0 || store_cnt - base_s !== 0) begin
            errors++;
            $display("[TB] FAIL badsync_pulses: got ready=%0d stores=%0d expected 0 0",
                     ready_cnt - base_r, store_cnt - base_s);
        end
    endtask

    task automatic test_pid_mismatch();
        start_pkt();
        checks++;
        if (bus.rx_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pidbad_error_clear: got %b expected 0", bus.rx_error);
        end
        send_byte(8'h80);
        send_byte(8'hA1);
        checks++;
        if (bus.rx_error !== 1'b1 || bus.rx_packet !== 4'h3) begin
            errors++;
            $display("[TB] FAIL pidbad_result: got error=%b pid=%h expected 1 3", bus.rx_error, bus.rx_packet);
        end
        finish_eop();
    endtask

    task automatic test_oversize();
        int base_s, base_r;
        base_s = store_cnt;
        base_r = ready_cnt;
        start_pkt();
        send_byte(8'h80);
        send_byte(8'h4B);
        for (int i = 0; i < MAX_PAYLOAD + 3; i++) begin
            send_byte(8'(8'h40 + i));
        end
        checks++;
        if (store_cnt - base_s !== MAX_PAYLOAD + 2 || bus.rx_error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL oversize_stores: got stores=%0d error=%b expected %0d 1",
                     store_cnt - base_s, bus.rx_error, MAX_PAYLOAD + 2);
        end
        checks++;
        if (bus.rx_byte_count !== CNT_W'(MAX_PAYLOAD + 2) || store_log[base_s + MAX_PAYLOAD + 1] !== 8'h49) begin
            errors++;
            $display("[TB] FAIL oversize_count: got count=%0d last=%h expected %0d 49",
                     bus.rx_byte_count, store_log[base_s + MAX_PAYLOAD + 1], MAX_PAYLOAD + 2);
        end
        finish_eop();
        checks++;
        if (ready_cnt - base_r !== 0 || bus.rx_packet !== 4'hB) begin
            errors++;
            $display("[TB] FAIL oversize_status: got ready=%0d pid=%h expected 0 b", ready_cnt - base_r, bus.rx_packet);
        end
    endtask

    task automatic test_fifo_full();
        int base_s, base_r;
        base_s = store_cnt;
        base_r = ready_cnt;
        start_pkt();
        send_byte(8'h80);
        send_byte(8'hC3);
        bus.buffer_occupancy = OCC_W'(BUF_DEPTH - 1);
        send_byte(8'h01);
        bus.buffer_occupancy = OCC_W'(BUF_DEPTH);
        send_byte(8'h02);
        checks++;
        if (bus.store_rx_packet_data !== 1'b0 || bus.rx_error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_reject: got store=%b error=%b expected 0 1",
                     bus.store_rx_packet_data, bus.rx_error);
        end
        checks++;
        if (store_cnt - base_s !== 1 || bus.rx_byte_count !== CNT_W'(1)) begin
            errors++;
            $display("[TB] FAIL full_count: got stores=%0d count=%0d expected 1 1",
                     store_cnt - base_s, bus.rx_byte_count);
        end
        bus.buffer_occupancy = '0;
        finish_eop();
        checks++;
        if (ready_cnt - base_r !== 0) begin
            errors++;
            $display("[TB] FAIL full_ready: got %0d expected 0", ready_cnt - base_r);
        end
    endtask

    task automatic test_reset_mid_data();
        int base_f;
        start_pkt();
        send_byte(8'h80);
        send_byte(8'hC3);
        base_f = flush_cnt;
        send_byte(8'h77);
        checks++;
        if (bus.store_rx_packet_data !== 1'b1 || bus.rx_packet_data !== 8'h77) begin
            errors++;
            $display("[TB] FAIL middata_store: got store=%b data=%h expected 1 77",
                     bus.store_rx_packet_data, bus.rx_packet_data);
        end
        n_rst = 1'b0;
        #1;
        checks++;
        if ({bus.rx_transfer_active, bus.rx_error, bus.rx_packet, bus.rx_data_ready,
             bus.rx_packet_data, bus.store_rx_packet_data, bus.flush, bus.rx_token,
             bus.rx_byte_count} !== '0) begin
            errors++;
            $display("[TB] FAIL middata_reset: got active=%b pid=%h data=%h store=%b count=%0d expected all 0",
                     bus.rx_transfer_active, bus.rx_packet, bus.rx_packet_data,
                     bus.store_rx_packet_data, bus.rx_byte_count);
        end
        tick();
        n_rst = 1'b1;
        tick(2);
        checks++;
        if (bus.rx_transfer_active !== 1'b0 || flush_cnt !== base_f) begin
            errors++;
            $display("[TB] FAIL middata_after: got active=%b flushes=%0d expected 0 %0d",
                     bus.rx_transfer_active, flush_cnt, base_f);
        end
    endtask

    task automatic test_back_to_back();
        int base_r;
        base_r = ready_cnt;
        start_pkt();
        send_byte(8'h80);
        send_byte(8'h69);
        send_byte(8'hCD);
        send_byte(8'hAB);
        tick();
        bus.eop = 1'b1;
        tick(2);
        bus.eop    = 1'b0;
        bus.d_edge = 1'b1;
        tick();
        bus.d_edge = 1'b0;
        checks++;
        if (bus.rx_transfer_active !== 1'b1 || bus.rx_packet !== 4'h9 || bus.rx_token !== 16'hABCD) begin
            errors++;
            $display("[TB] FAIL b2b_after_done: got active=%b pid=%h token=%h expected 1 9 abcd",
                     bus.rx_transfer_active, bus.rx_packet, bus.rx_token);
        end
        send_byte(8'h80);
        send_byte(8'hD2);
        finish_eop();
        checks++;
        if (bus.rx_packet !== 4'h2 || bus.rx_token !== 16'hABCD || ready_cnt - base_r !== 2) begin
            errors++;
            $display("[TB] FAIL b2b_ack: got pid=%h token=%h ready=%0d expected 2 abcd 2",
                     bus.rx_packet, bus.rx_token, ready_cnt - base_r);
        end
        start_pkt();
        send_byte(8'h00);
        tick();
        bus.eop = 1'b1;
        tick();
        bus.d_edge = 1'b1;
        tick();
        bus.d_edge = 1'b0;
        bus.eop    = 1'b0;
        checks++;
        if (bus.rx_transfer_active !== 1'b1 || bus.rx_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_after_err: got active=%b error=%b expected 1 0",
                     bus.rx_transfer_active, bus.rx_error);
        end
        send_byte(8'h80);
        send_byte(8'h2D);
        send_byte(8'h01);
        send_byte(8'h02);
        finish_eop();
        checks++;
        if (bus.rx_packet !== 4'hD || bus.rx_token !== 16'h0201 || ready_cnt - base_r !== 3) begin
            errors++;
            $display("[TB] FAIL b2b_setup: got pid=%h token=%h ready=%0d expected d 0201 3",
                     bus.rx_packet, bus.rx_token, ready_cnt - base_r);
        end
    endtask

    initial begin
        n_rst                = 1'b0;
        bus.d_edge           = 1'b0;
        bus.eop              = 1'b0;
        bus.byte_received    = 1'b0;
        bus.rcv_data         = 8'h00;
        bus.buffer_occupancy = '0;
        $display("[TB] starting usb_rx_pkt_ctrl directed tests");
        test_reset();
        test_out_token();
        test_data0();
        test_bad_sync();
        test_pid_mismatch();
        test_oversize();
        test_fifo_full();
        test_reset_mid_data();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end

endmodule
